text_cell_fetch: RTL and testbench

- Text-mode front end for the font ROM.
- Takes raw pixel coordinates and syncs from the VGA timing generator.
- Fetches each cell's 16-bit character/attribute word from the text buffer RAM, drives the font ROM with character, glyph row and glyph column, and converts the returned pixel into 12-bit RGB.
- Syncs, blanking and cursor are pipelined so they stay aligned with the pixel.

---
 rtl/vgacg_pkg.sv | 25 ++
 rtl/blink_timer.sv | 45 ++++
 rtl/text_cell_fetch.sv | 184 ++++++++++++++++++
 tb/tb_text_cell_fetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vgacg_pkg.sv
// Shared constants for the text-mode video path: cell geometry, pipeline
// depth, text-word field positions and the 16-colour CGA palette.
package vgacg_pkg;

  localparam int CELL_W   = 8;
  localparam int CELL_H   = 16;
  localparam int PIPE_LAT = 5;

  localparam int CHAR_LSB = 0;
  localparam int FG_LSB   = 8;
  localparam int BG_LSB   = 12;

  // {R,G,B} nibbles, standard CGA ordering (index 6 is brown, not dark yellow)
  localparam logic [11:0] PALETTE [0:15] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  function automatic logic [11:0] palette_lookup(input logic [3:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor blink timer: counts vsync assertion edges and toggles the blink
// phase every BLINK_FRAMES frames.
module blink_timer #(
  parameter int BLINK_FRAMES    = 30,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic phase
);

  localparam int               CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);
  localparam logic             SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic             vsync_prev_r;
  logic [CNT_W-1:0] count_r;
  logic             phase_r;
  logic             frame_edge_s;

  assign frame_edge_s = (vsync_prev_r == SYNC_IDLE) && (vsync != SYNC_IDLE);

  // Track previous vsync level, count frames and toggle phase on wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_prev_r <= SYNC_IDLE;
      count_r      <= {CNT_W{1'b0}};
      phase_r      <= 1'b0;
    end else begin
      vsync_prev_r <= vsync;
      if (frame_edge_s) begin
        if (count_r == CNT_LAST) begin
          count_r <= {CNT_W{1'b0}};
          phase_r <= ~phase_r;
        end else begin
          count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/text_cell_fetch.sv
// Text-mode front end: maps pixel coordinates to text cells, fetches the
// character/attribute word, drives the font ROM and colours the returned
// pixel. Every output lags its input by exactly PIPE_LAT cycles.
module text_cell_fetch
  import vgacg_pkg::*;
#(
  parameter int COLS            = 80,
  parameter int ROWS            = 30,
  parameter int ADDR_W          = 12,
  parameter int BLINK_FRAMES    = 30,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              active,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  input  logic              cursor_en,
  output logic [ADDR_W-1:0] text_addr,
  input  logic [15:0]       text_data,
  output logic              font_en,
  output logic [3:0]        font_page,
  output logic [7:0]        font_char,
  output logic [3:0]        font_vert,
  output logic [2:0]        font_horiz,
  input  logic              font_pixel,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam logic       SYNC_IDLE   = SYNC_ACTIVE_LOW;
  localparam logic [3:0] CURSOR_VPOS = 4'(CELL_H - 2);

  // Stage-0 decode of the incoming coordinates
  logic [6:0]        col_s;
  logic [5:0]        row_s;
  logic [ADDR_W-1:0] addr_s;
  logic              inrange_s;
  logic              cursor_s;
  logic              phase_s;

  assign col_s     = x[9:3];
  assign row_s     = y[9:4];
  assign addr_s    = ADDR_W'(32'(row_s) * 32'(COLS) + 32'(col_s));
  assign inrange_s = active && (32'(col_s) < 32'(COLS)) && (32'(row_s) < 32'(ROWS));
  assign cursor_s  = cursor_en && phase_s && (col_s == cursor_col) &&
                     (row_s == {1'b0, cursor_row}) && (y[3:0] >= CURSOR_VPOS);

  blink_timer #(
    .BLINK_FRAMES   (BLINK_FRAMES),
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_blink (
    .clk  (clk),
    .rst_n(rst_n),
    .vsync(vsync_in),
    .phase(phase_s)
  );

  // Pipeline registers; live*_r marks stages holding post-reset content
  logic [ADDR_W-1:0] text_addr_r;
  logic              live1_r, live2_r;
  logic              inrange1_r, inrange2_r, inrange3_r, inrange4_r;
  logic              cur1_r, cur2_r, cur3_r, cur4_r;
  logic [2:0]        hpos1_r, hpos2_r, hpos3_r;
  logic [3:0]        vpos1_r, vpos2_r;
  logic [3:0]        fg3_r, bg3_r, fg4_r, bg4_r;
  logic [PIPE_LAT-1:0] hs_pipe_r, vs_pipe_r;
  logic              font_en_r;
  logic [11:0]       rgb_r;
  logic [7:0]        font_char_s;
  logic [3:0]        color_idx_s;

  // Stage 1: register cell address, range/cursor flags and glyph position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      text_addr_r <= {ADDR_W{1'b0}};
      live1_r     <= 1'b0;
      inrange1_r  <= 1'b0;
      cur1_r      <= 1'b0;
      hpos1_r     <= 3'd0;
      vpos1_r     <= 4'd0;
    end else begin
      text_addr_r <= addr_s;
      live1_r     <= 1'b1;
      inrange1_r  <= inrange_s;
      cur1_r      <= cursor_s;
      hpos1_r     <= x[2:0];
      vpos1_r     <= y[3:0];
    end
  end

  // Stage 2: align with text_data arriving from the buffer RAM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live2_r    <= 1'b0;
      inrange2_r <= 1'b0;
      cur2_r     <= 1'b0;
      hpos2_r    <= 3'd0;
      vpos2_r    <= 4'd0;
    end else begin
      live2_r    <= live1_r;
      inrange2_r <= inrange1_r;
      cur2_r     <= cur1_r;
      hpos2_r    <= hpos1_r;
      vpos2_r    <= vpos1_r;
    end
  end

  // Stages 3-4: capture attributes and carry them to the font pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inrange3_r <= 1'b0;
      cur3_r     <= 1'b0;
      hpos3_r    <= 3'd0;
      fg3_r      <= 4'd0;
      bg3_r      <= 4'd0;
      inrange4_r <= 1'b0;
      cur4_r     <= 1'b0;
      fg4_r      <= 4'd0;
      bg4_r      <= 4'd0;
    end else begin
      inrange3_r <= inrange2_r;
      cur3_r     <= cur2_r;
      hpos3_r    <= hpos2_r;
      fg3_r      <= text_data[FG_LSB +: 4];
      bg3_r      <= text_data[BG_LSB +: 4];
      inrange4_r <= inrange3_r;
      cur4_r     <= cur3_r;
      fg4_r      <= fg3_r;
      bg4_r      <= bg3_r;
    end
  end

  // Glyph select comes straight from the RAM word, muted until the pipe fills
  always_comb begin
    font_char_s = 8'd0;
    if (live2_r) begin
      font_char_s = text_data[CHAR_LSB +: 8];
    end else begin
      font_char_s = 8'd0;
    end
  end

  // Pick foreground or background index; cursor inverts the glyph pixel
  always_comb begin
    color_idx_s = bg4_r;
    if (font_pixel ^ cur4_r) begin
      color_idx_s = fg4_r;
    end else begin
      color_idx_s = bg4_r;
    end
  end

  // Output stage: colour, delayed syncs and font enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_r     <= 12'h000;
      hs_pipe_r <= {PIPE_LAT{SYNC_IDLE}};
      vs_pipe_r <= {PIPE_LAT{SYNC_IDLE}};
      font_en_r <= 1'b0;
    end else begin
      rgb_r     <= inrange4_r ? palette_lookup(color_idx_s) : 12'h000;
      hs_pipe_r <= {hs_pipe_r[PIPE_LAT-2:0], hsync_in};
      vs_pipe_r <= {vs_pipe_r[PIPE_LAT-2:0], vsync_in};
      font_en_r <= 1'b1;
    end
  end

  assign text_addr  = text_addr_r;
  assign font_en    = font_en_r;
  assign font_page  = 4'd0;
  assign font_char  = font_char_s;
  assign font_vert  = vpos2_r;
  assign font_horiz = hpos3_r;
  assign rgb        = rgb_r;
  assign hsync_out  = hs_pipe_r[PIPE_LAT-1];
  assign vsync_out  = vs_pipe_r[PIPE_LAT-1];

endmodule

// File: tb/tb_text_cell_fetch.sv
// Directed bench for text_cell_fetch with a text RAM and font ROM model.
module tb_text_cell_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  x, y;
  logic        active, hsync_in, vsync_in;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_en;
  logic [11:0] text_addr;
  logic [15:0] text_data;
  logic        font_en;
  logic [3:0]  font_page;
  logic [7:0]  font_char;
  logic [3:0]  font_vert;
  logic [2:0]  font_horiz;
  logic        font_pixel;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int checks = 0;
  int errors = 0;
  int pix_mode;  // 0: ROM model, 1: force 1, 2: force 0

  always #5 clk = ~clk;

  text_cell_fetch #(
    .COLS(80), .ROWS(30), .ADDR_W(12), .BLINK_FRAMES(2), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
    .text_addr(text_addr), .text_data(text_data), .font_en(font_en),
    .font_page(font_page), .font_char(font_char), .font_vert(font_vert),
    .font_horiz(font_horiz), .font_pixel(font_pixel), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  logic [15:0] ram [0:4095];

  // Text RAM: one-cycle registered read
  always @(posedge clk) text_data <= ram[text_addr];

  function automatic logic glyph_bit(input logic [7:0] c, input logic [3:0] v, input logic [2:0] h);
    logic [7:0] r;
    if (c == 8'h41) begin
      case (v)
        4'd2:    r = 8'h10;
        4'd3:    r = 8'h38;
        4'd4:    r = 8'h6C;
        4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: r = 8'hC6;
        4'd7:    r = 8'hFE;
        default: r = 8'h00;
      endcase
    end else begin
      r = c ^ {v, v};
    end
    return r[3'd7 - h];
  endfunction

  // Font ROM: char/row registered first, column applied on the data edge
  logic [7:0] rom_char_q;
  logic [3:0] rom_vert_q;
  always @(posedge clk) begin
    rom_char_q <= font_char;
    rom_vert_q <= font_vert;
    if (pix_mode == 1)      font_pixel <= 1'b1;
    else if (pix_mode == 2) font_pixel <= 1'b0;
    else                    font_pixel <= glyph_bit(rom_char_q, rom_vert_q, font_horiz);
  end

  // Expected-value delay line, index k = k+1 edges after the input
  logic [11:0] e_rgb [0:4];
  logic        e_hs  [0:4];
  logic        e_vs  [0:4];
  logic [7:0]  e_chr [0:4];
  logic [3:0]  e_vrt [0:4];
  logic [2:0]  e_hz  [0:4];
  logic        e_chk [0:4];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [9:0] xi, input logic [9:0] yi, input logic act,
                     input logic hs, input logic vs, input logic [11:0] er, input logic chk);
    logic [11:0] a;
    x = xi; y = yi; active = act; hsync_in = hs; vsync_in = vs;
    a = 12'(int'(yi[9:4]) * 80 + int'(xi[9:3]));
    for (int i = 4; i > 0; i--) begin
      e_rgb[i] = e_rgb[i-1]; e_hs[i] = e_hs[i-1]; e_vs[i] = e_vs[i-1];
      e_chr[i] = e_chr[i-1]; e_vrt[i] = e_vrt[i-1]; e_hz[i] = e_hz[i-1];
      e_chk[i] = e_chk[i-1];
    end
    e_rgb[0] = er; e_hs[0] = hs; e_vs[0] = vs;
    e_chr[0] = ram[a][7:0]; e_vrt[0] = yi[3:0]; e_hz[0] = xi[2:0]; e_chk[0] = chk;
    tick();
    if (e_chk[1]) begin
      check("font_char", {8'd0, font_char}, {8'd0, e_chr[1]});
      check("font_vert", {12'd0, font_vert}, {12'd0, e_vrt[1]});
    end
    if (e_chk[2]) check("font_horiz", {13'd0, font_horiz}, {13'd0, e_hz[2]});
    if (e_chk[4]) begin
      check("rgb", {4'd0, rgb}, {4'd0, e_rgb[4]});
      check("hsync_out", {15'd0, hsync_out}, {15'd0, e_hs[4]});
      check("vsync_out", {15'd0, vsync_out}, {15'd0, e_vs[4]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1);
  endtask

  task automatic vpulse();
    cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1);
    cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1);
    idle(3);
  endtask

  // Cursor cell (3,2): rows 14/15 show e14, row 13 and the next cell never invert
  task automatic cursor_probe(input logic [11:0] e14);
    cyc(10'd24, 10'd46, 1'b1, 1'b1, 1'b1, e14, 1'b1);
    cyc(10'd31, 10'd47, 1'b1, 1'b1, 1'b1, e14, 1'b1);
    cyc(10'd24, 10'd45, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    cyc(10'd32, 10'd46, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    idle(5);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
    ram[0]   = 16'h0F41;  // 'A', fg 15, bg 0
    ram[2]   = 16'h1F00;  // fg 15, bg 1
    ram[163] = 16'h1E20;  // cursor cell: fg 14, bg 1
    for (int i = 0; i < 5; i++) e_chk[i] = 1'b0;
    rst_n = 1'b0; x = 10'd0; y = 10'd0; active = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    cursor_col = 7'd3; cursor_row = 5'd2; cursor_en = 1'b0;
    pix_mode = 2;

    // Reset state
    tick(); tick();
    check("rst_rgb", {4'd0, rgb}, 16'h0000);
    check("rst_text_addr", {4'd0, text_addr}, 16'h0000);
    check("rst_font_en", {15'd0, font_en}, 16'h0000);
    check("rst_hsync", {15'd0, hsync_out}, 16'h0001);
    check("rst_vsync", {15'd0, vsync_out}, 16'h0001);
    check("rst_font_char", {8'd0, font_char}, 16'h0000);
    check("rst_font_vert", {12'd0, font_vert}, 16'h0000);
    check("rst_font_horiz", {13'd0, font_horiz}, 16'h0000);
    check("font_page", {12'd0, font_page}, 16'h0000);

    rst_n = 1'b1;
    idle(6);
    check("font_en", {15'd0, font_en}, 16'h0001);

    // Addressing, including the last cell
    cyc(10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    check("addr_last", {4'd0, text_addr}, 16'd2399);
    cyc(10'd8, 10'd16, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    check("addr_81", {4'd0, text_addr}, 16'd81);
    cyc(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    check("addr_0", {4'd0, text_addr}, 16'd0);
    idle(5);

    // Latency: single lit pixel with an hsync pulse
    pix_mode = 1;
    idle(5);
    cyc(10'd16, 10'd0, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b1);
    idle(6);
    pix_mode = 2;
    idle(5);
    cyc(10'd16, 10'd0, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    idle(5);

    // Blanking with the ROM pixel forced on
    pix_mode = 1;
    idle(5);
    cyc(10'd16, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1);
    cyc(10'd640, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    cyc(10'd0, 10'd480, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    cyc(10'd16, 10'd0, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    idle(6);

    // Glyph alignment through the ROM model, cell 0 = 'A'
    pix_mode = 0;
    idle(5);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 8; xx++)
        cyc(10'(xx), 10'(yy), 1'b1, 1'b1, 1'b1,
            glyph_bit(8'h41, 4'(yy), 3'(xx)) ? 12'hFFF : 12'h000, 1'b1);
    idle(6);

    // Cursor blink with BLINK_FRAMES=2
    pix_mode = 2;
    cursor_en = 1'b1;
    idle(5);
    cursor_probe(12'h00A);
    vpulse(); cursor_probe(12'h00A);
    vpulse(); cursor_probe(12'hFF5);
    cursor_en = 1'b0;
    cyc(10'd24, 10'd46, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    idle(5);
    cursor_en = 1'b1;
    vpulse(); cursor_probe(12'hFF5);
    vpulse(); cursor_probe(12'h00A);
    vpulse(); cursor_probe(12'h00A);
    vpulse(); cursor_probe(12'hFF5);

    // Mid-line reset with syncs active in the pipe
    pix_mode = 1;
    idle(5);
    for (int i = 0; i < 6; i++) cyc(10'd16, 10'd0, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1);
    for (int i = 0; i < 5; i++) e_chk[i] = 1'b0;
    rst_n = 1'b0;
    cyc(10'd16, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0);
    check("mid_rst_rgb", {4'd0, rgb}, 16'h0000);
    check("mid_rst_hsync", {15'd0, hsync_out}, 16'h0001);
    check("mid_rst_vsync", {15'd0, vsync_out}, 16'h0001);
    check("mid_rst_font_en", {15'd0, font_en}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(10'd16, 10'd0, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
      check("post_rst_blank", {4'd0, rgb}, 16'h0000);
    end
    check("post_rst_hsync", {15'd0, hsync_out}, 16'h0001);
    cyc(10'd16, 10'd0, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    idle(6);

    // Blink phase cleared by reset
    pix_mode = 2;
    idle(5);
    cyc(10'd24, 10'd46, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
